// File: rtl/softmax_topk_select_pkg.sv
// Shared types and constants for the softmax top-3 selector: FSM encoding,
// list depth, default MLP widths and a helper that packs the rank slots.
package softmax_topk_select_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam int TOPK            = 3;
  localparam int SLOT_W          = 32;
  localparam int DEF_DATA_WIDTH  = 8;
  localparam int DEF_NUM_CLASSES = 387;
  localparam int DEF_IDX_WIDTH   = 9;

  // Packs three lanes of width w (w <= SLOT_W) contiguously, rank1 in the LSBs.
  function automatic logic [TOPK*SLOT_W-1:0] pack_slots(
    input logic [SLOT_W-1:0] s0,
    input logic [SLOT_W-1:0] s1,
    input logic [SLOT_W-1:0] s2,
    input int                w
  );
    logic [TOPK*SLOT_W-1:0] r;
    r = '0;
    for (int b = 0; b < SLOT_W; b++) begin
      if (b < w) begin
        r[b]       = s0[b];
        r[w + b]   = s1[b];
        r[2*w + b] = s2[b];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/softmax_topk_select_if.sv
// Result port of the top-3 selector towards the readout/host side.
// Handshake: the source raises out_valid with top_idx/top_val stable and keeps them
// unchanged until a rising clock edge sees out_valid && out_ready; that edge transfers.
interface softmax_topk_select_if #(
  parameter int DATA_WIDTH = 8,
  parameter int IDX_WIDTH  = 9
);
  logic                    out_valid;
  logic                    out_ready;
  logic [3*IDX_WIDTH-1:0]  top_idx;
  logic [3*DATA_WIDTH-1:0] top_val;

  modport master (
    output out_valid,
    output top_idx,
    output top_val,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  top_idx,
    input  top_val,
    output out_ready
  );
endinterface

// File: rtl/softmax_topk_select_topk_insert_cell.sv
// Combinational insertion of one (value, index) into a 3-entry list sorted by
// descending value; equal values stay behind the entry already present.
module topk_insert_cell
  import softmax_topk_select_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int IDX_WIDTH  = DEF_IDX_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] in_val,
  input  logic [IDX_WIDTH-1:0]  in_idx,
  input  logic [DATA_WIDTH-1:0] slot_val_i [TOPK],
  input  logic [IDX_WIDTH-1:0]  slot_idx_i [TOPK],
  input  logic [TOPK-1:0]       slot_vld_i,
  output logic [DATA_WIDTH-1:0] slot_val_o [TOPK],
  output logic [IDX_WIDTH-1:0]  slot_idx_o [TOPK],
  output logic [TOPK-1:0]       slot_vld_o
);

  logic [TOPK-1:0] take;

  always_comb begin
    for (int j = 0; j < TOPK; j++) begin
      take[j] = !slot_vld_i[j] || (in_val > slot_val_i[j]);
    end
  end

  // The first slot that would take the new entry is its rank; everything below shifts down.
  always_comb begin
    slot_val_o = slot_val_i;
    slot_idx_o = slot_idx_i;
    slot_vld_o = slot_vld_i;

    if (take[0]) begin
      slot_val_o[0] = in_val;
      slot_idx_o[0] = in_idx;
      slot_vld_o[0] = 1'b1;
    end

    if (take[0]) begin
      slot_val_o[1] = slot_val_i[0];
      slot_idx_o[1] = slot_idx_i[0];
      slot_vld_o[1] = slot_vld_i[0];
    end else if (take[1]) begin
      slot_val_o[1] = in_val;
      slot_idx_o[1] = in_idx;
      slot_vld_o[1] = 1'b1;
    end

    if (take[0] || take[1]) begin
      slot_val_o[2] = slot_val_i[1];
      slot_idx_o[2] = slot_idx_i[1];
      slot_vld_o[2] = slot_vld_i[1];
    end else if (take[2]) begin
      slot_val_o[2] = in_val;
      slot_idx_o[2] = in_idx;
      slot_vld_o[2] = 1'b1;
    end
  end

endmodule

// File: rtl/softmax_topk_select.sv
// Captures a softmax vector on start, scans it one class per cycle into a sorted
// top-3 list, then offers the ranked result over a valid/ready port.
module softmax_topk_select
  import softmax_topk_select_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int NUM_CLASSES = DEF_NUM_CLASSES,
  parameter int IDX_WIDTH   = DEF_IDX_WIDTH
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [DATA_WIDTH*NUM_CLASSES-1:0] softmax_in,
  input  logic                              start,
  output logic                              busy,
  output state_t                            dbg_state,
  softmax_topk_select_if.master             res
);

  state_t                            state_q, state_d;
  logic [IDX_WIDTH-1:0]              cnt_q, cnt_d;
  logic [DATA_WIDTH*NUM_CLASSES-1:0] cap_q, cap_d;
  logic [DATA_WIDTH-1:0]             slot_val_q [TOPK];
  logic [DATA_WIDTH-1:0]             slot_val_d [TOPK];
  logic [IDX_WIDTH-1:0]              slot_idx_q [TOPK];
  logic [IDX_WIDTH-1:0]              slot_idx_d [TOPK];
  logic [TOPK-1:0]                   slot_vld_q, slot_vld_d;
  logic [TOPK*IDX_WIDTH-1:0]         top_idx_q, top_idx_d;
  logic [TOPK*DATA_WIDTH-1:0]        top_val_q, top_val_d;

  logic [DATA_WIDTH-1:0]             cur_val;
  logic                              last_elem;
  logic [DATA_WIDTH-1:0]             ins_val [TOPK];
  logic [IDX_WIDTH-1:0]              ins_idx [TOPK];
  logic [TOPK-1:0]                   ins_vld;
  logic [TOPK*SLOT_W-1:0]            val_wide, idx_wide;

  assign cur_val   = cap_q[DATA_WIDTH*int'(cnt_q) +: DATA_WIDTH];
  assign last_elem = (cnt_q == IDX_WIDTH'(NUM_CLASSES - 1));

  topk_insert_cell #(
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_WIDTH  (IDX_WIDTH)
  ) u_insert (
    .in_val     (cur_val),
    .in_idx     (cnt_q),
    .slot_val_i (slot_val_q),
    .slot_idx_i (slot_idx_q),
    .slot_vld_i (slot_vld_q),
    .slot_val_o (ins_val),
    .slot_idx_o (ins_idx),
    .slot_vld_o (ins_vld)
  );

  always_comb begin
    val_wide = pack_slots(SLOT_W'(ins_val[0]), SLOT_W'(ins_val[1]), SLOT_W'(ins_val[2]),
                          DATA_WIDTH);
    idx_wide = pack_slots(SLOT_W'(ins_idx[0]), SLOT_W'(ins_idx[1]), SLOT_W'(ins_idx[2]),
                          IDX_WIDTH);
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cap_d      = cap_q;
    slot_val_d = slot_val_q;
    slot_idx_d = slot_idx_q;
    slot_vld_d = slot_vld_q;
    top_idx_d  = top_idx_q;
    top_val_d  = top_val_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          cap_d      = softmax_in;
          slot_vld_d = '0;
          cnt_d      = '0;
          state_d    = ST_SCAN;
        end
      end

      ST_SCAN: begin
        slot_val_d = ins_val;
        slot_idx_d = ins_idx;
        slot_vld_d = ins_vld;
        if (last_elem) begin
          // Publish straight from the insertion result so HOLD sees the final list.
          top_val_d = val_wide[TOPK*DATA_WIDTH-1:0];
          top_idx_d = idx_wide[TOPK*IDX_WIDTH-1:0];
          state_d   = ST_HOLD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_HOLD: begin
        if (res.out_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      slot_val_q <= '{default: '0};
      slot_idx_q <= '{default: '0};
      slot_vld_q <= '0;
      top_idx_q  <= '0;
      top_val_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      slot_val_q <= slot_val_d;
      slot_idx_q <= slot_idx_d;
      slot_vld_q <= slot_vld_d;
      top_idx_q  <= top_idx_d;
      top_val_q  <= top_val_d;
    end
  end

  // Pure data buffer: only meaningful after a capture, so it needs no reset.
  always_ff @(posedge clk) begin
    cap_q <= cap_d;
  end

  assign busy          = (state_q != ST_IDLE);
  assign dbg_state     = state_q;
  assign res.out_valid = (state_q == ST_HOLD);
  assign res.top_idx   = top_idx_q;
  assign res.top_val   = top_val_q;

endmodule

// File: tb/tb_softmax_topk_select.sv
// Bench for softmax_topk_select: fixed vector table, handshake/abort sequences
// and random vectors scored against a sort-based top-3 reference.
module tb_softmax_topk_select;
  import softmax_topk_select_pkg::*;

  localparam int DW    = 8;
  localparam int NC    = 387;
  localparam int IW    = 9;
  localparam int RW    = 3*IW + 3*DW;
  localparam int LIMIT = NC + 50;

  // ---------------- clock / reset ----------------
  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           start = 1'b0;
  logic [DW*NC-1:0] softmax_in = '0;
  logic           busy;
  state_t         dbg_state;

  softmax_topk_select_if #(.DATA_WIDTH(DW), .IDX_WIDTH(IW)) res_if ();

  softmax_topk_select #(
    .DATA_WIDTH  (DW),
    .NUM_CLASSES (NC),
    .IDX_WIDTH   (IW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .softmax_in (softmax_in),
    .start      (start),
    .busy       (busy),
    .dbg_state  (dbg_state),
    .res        (res_if)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int               tests_run = 0;
  int               tests_failed = 0;
  logic [RW-1:0]    exp_q[$];
  logic [DW-1:0]    cls [NC];

  typedef struct {
    int              mode;
    logic [3*IW-1:0] exp_idx;
    logic [3*DW-1:0] exp_val;
  } vec_t;
  vec_t vecs [6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Reference: repeated maximum selection; strict '>' keeps the lowest index on ties.
  function automatic logic [RW-1:0] model_topk();
    bit              taken [NC];
    logic [3*IW-1:0] idx;
    logic [3*DW-1:0] val;
    int              best;
    idx = '0;
    val = '0;
    for (int i = 0; i < NC; i++) taken[i] = 1'b0;
    for (int r = 0; r < 3; r++) begin
      best = -1;
      for (int i = 0; i < NC; i++) begin
        if (!taken[i] && (best < 0 || cls[i] > cls[best])) best = i;
      end
      taken[best] = 1'b1;
      idx[r*IW +: IW] = IW'(best);
      val[r*DW +: DW] = cls[best];
    end
    return {idx, val};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic build(input int mode);
    for (int i = 0; i < NC; i++) begin
      case (mode)
        0:       cls[i] = DW'(i % 251);
        1:       cls[i] = 8'h40;
        2:       cls[i] = 8'd1;
        3:       cls[i] = 8'd0;
        4:       cls[i] = 8'd0;
        5:       cls[i] = DW'(i % 256);
        10:      cls[i] = DW'($urandom_range(0, 255));
        11:      cls[i] = DW'($urandom_range(0, 3));
        default: cls[i] = DW'($urandom_range(250, 255));
      endcase
    end
    if (mode == 0) begin
      cls[300] = 8'd255;
      cls[10]  = 8'd254;
      cls[5]   = 8'd253;
    end
    if (mode == 2) cls[NC-1] = 8'd255;
    if (mode == 4) begin
      cls[7]   = 8'd200;
      cls[3]   = 8'd200;
      cls[100] = 8'd199;
    end
  endtask

  task automatic apply_vec();
    for (int i = 0; i < NC; i++) softmax_in[i*DW +: DW] = cls[i];
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (res_if.out_valid !== 1'b1 && n < LIMIT) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= LIMIT) begin
      tests_run++;
      tests_failed++;
      $display("FAIL valid_timeout: got no out_valid within %0d cycles", LIMIT);
    end
  endtask

  task automatic score(input string name);
    if (exp_q.size() == 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL %s: got a result with no expected entry queued", name);
    end else begin
      check(name, 64'({res_if.top_idx, res_if.top_val}), 64'(exp_q.pop_front()));
    end
  endtask

  task automatic accept();
    res_if.out_ready = 1'b1;
    @(posedge clk);
    #1;
    res_if.out_ready = 1'b0;
    check("valid_drop", 64'(res_if.out_valid), 64'(0));
    check("busy_after", 64'(busy), 64'(0));
  endtask

  task automatic run_txn(input string name, input logic [RW-1:0] expv);
    int n;
    exp_q.push_back(expv);
    apply_vec();
    pulse_start();
    wait_valid(n);
    check({name, "_latency"}, 64'(n), 64'(NC));
    score(name);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int                n;
    logic [RW-1:0]     held;
    logic [RW-1:0]     first_exp;

    vecs[0] = '{0, {9'd5,   9'd10,  9'd300}, {8'd253, 8'd254, 8'd255}};
    vecs[1] = '{1, {9'd2,   9'd1,   9'd0},   {8'h40,  8'h40,  8'h40}};
    vecs[2] = '{2, {9'd1,   9'd0,   9'd386}, {8'd1,   8'd1,   8'd255}};
    vecs[3] = '{3, {9'd2,   9'd1,   9'd0},   {8'd0,   8'd0,   8'd0}};
    vecs[4] = '{4, {9'd100, 9'd7,   9'd3},   {8'd199, 8'd200, 8'd200}};
    vecs[5] = '{5, {9'd253, 9'd254, 9'd255}, {8'd253, 8'd254, 8'd255}};

    res_if.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    check("reset_busy",  64'(busy), 64'(0));
    check("reset_valid", 64'(res_if.out_valid), 64'(0));
    check("reset_idx",   64'(res_if.top_idx), 64'(0));
    check("reset_val",   64'(res_if.top_val), 64'(0));
    check("reset_state", 64'(dbg_state), 64'(ST_IDLE));

    // Table-driven vectors.
    for (int k = 0; k < 6; k++) begin
      build(vecs[k].mode);
      run_txn($sformatf("vec%0d", k), {vecs[k].exp_idx, vecs[k].exp_val});
      accept();
    end

    // Result held under back-pressure, then accept together with an ignored start.
    build(1);
    held = {vecs[1].exp_idx, vecs[1].exp_val};
    run_txn("hold", held);
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      check("hold_valid", 64'(res_if.out_valid), 64'(1));
      check("hold_data",  64'({res_if.top_idx, res_if.top_val}), 64'(held));
    end
    res_if.out_ready = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    res_if.out_ready = 1'b0;
    start = 1'b0;
    check("hs_valid_drop", 64'(res_if.out_valid), 64'(0));
    check("hs_busy",       64'(busy), 64'(0));
    @(posedge clk);
    #1;
    check("hs_start_ignored", 64'(busy), 64'(0));
    check("retain_data", 64'({res_if.top_idx, res_if.top_val}), 64'(held));

    // Start during SCAN and HOLD is ignored; later input changes have no effect.
    build(0);
    first_exp = {vecs[0].exp_idx, vecs[0].exp_val};
    exp_q.push_back(first_exp);
    apply_vec();
    pulse_start();
    repeat (99) @(posedge clk);
    #1;
    softmax_in = '1;
    pulse_start();
    check("scan_busy", 64'(busy), 64'(1));
    wait_valid(n);
    check("restart_latency", 64'(100 + n), 64'(NC));
    score("restart_result");
    pulse_start();
    check("hold_start_state", 64'(dbg_state), 64'(ST_HOLD));
    check("hold_start_data", 64'({res_if.top_idx, res_if.top_val}), 64'(first_exp));
    accept();
    @(posedge clk);
    #1;
    check("not_queued", 64'(busy), 64'(0));

    // Reset in the middle of a scan discards everything.
    build(5);
    apply_vec();
    pulse_start();
    repeat (199) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("abort_busy",  64'(busy), 64'(0));
    check("abort_valid", 64'(res_if.out_valid), 64'(0));
    check("abort_idx",   64'(res_if.top_idx), 64'(0));
    check("abort_val",   64'(res_if.top_val), 64'(0));
    build(4);
    run_txn("after_abort", {vecs[4].exp_idx, vecs[4].exp_val});
    accept();

    // Maximum in the last class with the consumer always ready.
    build(2);
    res_if.out_ready = 1'b1;
    run_txn("last_max", {vecs[2].exp_idx, vecs[2].exp_val});
    @(posedge clk);
    #1;
    check("one_cycle_valid", 64'(res_if.out_valid), 64'(0));
    res_if.out_ready = 1'b0;
    @(posedge clk);
    #1;

    // Random vectors against the reference model, random consumer delay.
    for (int r = 0; r < 8; r++) begin
      build(10 + (r % 3));
      run_txn($sformatf("rand%0d", r), model_topk());
      repeat ($urandom_range(0, 5)) begin
        @(posedge clk);
        #1;
        check("rand_hold", 64'(res_if.out_valid), 64'(1));
      end
      accept();
    end

    check("queue_empty", 64'(exp_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
